// File: rtl/serial_add_controller.sv
// Sequential WIDTH-bit adder/subtractor built around one shared 2-bit full-adder slice.
// The slice consumes two operand bits per clock, LSB first, and a registered carry links the steps.
module two_bit_full_adder (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  input  logic       i_cin,
  output logic [1:0] o_sum,
  output logic       o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {2'b00, i_cin};
endmodule

module serial_add_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic [1:0]       o_dbg_state
);
  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_count;
  logic             r_carry;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [1:0]       w_sum;
  logic             w_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_next;

  two_bit_full_adder u_slice (
    .i_a    (r_op_a[1:0]),
    .i_b    (r_op_b[1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Each slice sum enters at the top, so after N steps the LSB pair sits at the bottom.
  if (WIDTH == 2) begin : g_acc_w2
    assign w_acc_next = w_sum;
  end else begin : g_acc_wn
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:2]};
  end

  assign w_last = (r_count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    ready       = (r_state == S_IDLE);
    busy        = (r_state == S_RUN);
    done        = (r_state == S_DONE);
    o_dbg_state = r_state;
  end

  // Subtraction is A + ~B + 1: B is inverted at accept and the +1 rides in as the first carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_carry   <= 1'b0;
      r_a_msb   <= 1'b0;
      r_b_msb   <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op_a  <= a;
            r_op_b  <= op_sub ? ~b : b;
            r_acc   <= '0;
            r_carry <= op_sub;
            r_count <= '0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= op_sub ? ~b[WIDTH-1] : b[WIDTH-1];
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_op_a  <= r_op_a >> 2;
          r_op_b  <= r_op_b >> 2;
          r_carry <= w_cout;
          r_count <= r_count + CW'(1);
          if (w_last) begin
            result    <= w_acc_next;
            carry_out <= w_cout;
            overflow  <= (r_a_msb == r_b_msb) && (w_sum[1] != r_a_msb);
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: doc/serial_add_controller.md
Name: serial_add_controller

Overview:
- Multi-cycle sequencer that adds or subtracts WIDTH-bit operands by reusing one two_bit_full_adder slice, 2 bits per clock, LSB first.
- A start/ready/done handshake wraps the sequencing.
- The registered carry is fed back into the slice Cin between steps.
- Sits between a requesting datapath and the shared 2-bit adder resource, so wide arithmetic needs no wide adder.

Parameters:
- WIDTH, 8, operand/result width in bits; must be even and >= 2; N = WIDTH/2 slice steps per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while ready=1
- op_sub  input  1  0 = A+B, 1 = A-B; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- ready  output  1  high only in IDLE; combinational from state
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse in DONE state
- result  output  WIDTH  registered sum/difference; held until the next completion
- carry_out  output  1  final carry; for subtract, 1 = no borrow (a >= b unsigned)
- overflow  output  1  two's-complement signed overflow of the final operation

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - rst_n=0 forces state=IDLE, step counter=0, internal shift/carry registers=0.
  - Outputs: result=0, carry_out=0, overflow=0, done=0, busy=0, ready=1.
  - Reset mid-operation aborts it, with no done pulse and no result update.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - On an edge with start=1, latch opA=a and opB = op_sub ? ~b : b.
  - Set carry=op_sub and count=0, record the MSBs of a and opB, then go to RUN.
- RUN: each edge performs one slice step.
  - Slice inputs: A=opA[1:0], B=opB[1:0], Cin=carry.
  - The slice sum shifts into the top of the accumulator; opA and opB shift right by 2; carry <= slice Cout; count++.
  - On the edge where count==N-1, go to DONE and commit:
    - result <= final accumulator;
    - carry_out <= final Cout;
    - overflow <= (a_msb == opB_msb) && (result_msb != a_msb).
- DONE: done=1 for exactly one cycle; next edge returns to IDLE.
- Latency: accept edge E0, slice edges E1..EN, done high between EN and EN+1.
  - For WIDTH=8: done is high in the 5th cycle after accept.
  - Minimum issue interval is N+2 edges (start held high gives back-to-back operations).
- start in RUN or DONE is ignored, not queued.
- Changes on a, b or op_sub after the accept edge have no effect.
- result, carry_out and overflow change only at the commit edge or reset; they stay stable through IDLE and the next RUN.
- Arithmetic is modulo 2^WIDTH, with no saturation.
- WIDTH=2 gives N=1: RUN lasts a single edge.

Test Plan:
- WIDTH=8, add 0x5A+0x33 -> after the done pulse: result=0x8D, carry_out=0, overflow=1; done high exactly 1 cycle, 5 cycles after accept.
- Subtract 0x10-0x20 -> result=0xF0, carry_out=0 (borrow), overflow=0; subtract 0x20-0x10 -> 0x10, carry_out=1.
- Add 0xFF+0x01 -> result=0x00, carry_out=1, overflow=0; add 0x7F+0x01 -> 0x80, carry_out=0, overflow=1.
- start held high with new operands each accept -> accepts every 6 edges; ready low during RUN/DONE; operands changed mid-RUN do not alter the result.
- Assert rst_n=0 at the 2nd RUN cycle of 0x5A+0x33 -> immediately ready=1, busy=0, result=0, and no done pulse.
- A new start after reset completes correctly.
